ram12x73_fifo_ctrl: RTL and testbench

- Client-side controller for the router's 12x73 vendor RAM macro (2-cycle registered read latency).
- Drives the macro's write and read ports and presents a valid/ready FIFO to router logic.
- Hides the read latency with a small register output buffer, giving 1 word/cycle sustained throughput.
- Sits between the router ingress queue and the vendor memory wrapper. BIST ports are not handled here.

---
 rtl/ram12x73_pkg.sv | 23 ++
 rtl/ram_rd_obuf.sv | 58 +++++
 rtl/ram12x73_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_ram12x73_fifo_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram12x73_pkg.sv
// rtl/ram12x73_pkg.sv - shared constants, word type and pointer helper for the 12x73 RAM FIFO controller
//
// Purpose: single source for the RAM geometry, read latency and output buffer
// sizing used by ram12x73_fifo_ctrl and ram_rd_obuf.
// Ports: none (package).
package ram12x73_pkg;

  localparam int WIDTH  = 73;   // data word width
  localparam int DEPTH  = 12;   // RAM entries
  localparam int AW     = 4;    // RAM address width
  localparam int RD_LAT = 2;    // ram_rd_en edge to valid ram_rd_data
  localparam int OBUF   = 3;    // output buffer entries (RD_LAT+1)
  localparam int CW     = 4;    // occupancy counter width, holds 0..15
  localparam int OW     = 2;    // output buffer pointer/count width

  typedef logic [WIDTH-1:0] word_t;

  // RAM pointer increment; DEPTH is not a power of two so wrap explicitly.
  function automatic logic [AW-1:0] ram_ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

endpackage

// File: rtl/ram_rd_obuf.sv
// rtl/ram_rd_obuf.sv - small register FIFO that absorbs RAM read returns
//
// Purpose: OBUF-entry circular register FIFO holding words returned by the RAM
// macro until the consumer pops them. Simultaneous push and pop are allowed;
// the caller guarantees it never pushes into a full buffer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         capture push_data this cycle
//   push_data    word returned by the RAM
//   pop          remove the head entry this cycle
//   head_data    head entry (register output, 0 after reset)
//   cnt          number of entries held, 0..OBUF
//   valid        buffer holds at least one entry
module ram_rd_obuf
  import ram12x73_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  word_t         push_data,
  input  logic          pop,
  output word_t         head_data,
  output logic [OW-1:0] cnt,
  output logic          valid
);

  word_t         mem [OBUF];
  logic [OW-1:0] wp;
  logic [OW-1:0] rp;

  function automatic logic [OW-1:0] obuf_inc(input logic [OW-1:0] p);
    return (p == OW'(OBUF - 1)) ? '0 : p + OW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF; i++) mem[i] <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= obuf_inc(wp);
      end
      if (pop) rp <= obuf_inc(rp);
      case ({push, pop})
        2'b10:   cnt <= cnt + OW'(1);
        2'b01:   cnt <= cnt - OW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_data = mem[rp];
  assign valid     = (cnt != '0);

endmodule

// File: rtl/ram12x73_fifo_ctrl.sv
// rtl/ram12x73_fifo_ctrl.sv - valid/ready FIFO controller around the 12x73 RAM macro
//
// Purpose: drives the write and read ports of a 12x73 RAM with 2-cycle read
// latency and presents a valid/ready FIFO. A 3-entry register buffer behind
// the RAM read port hides the latency for 1 word/cycle throughput.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid, in_ready, in_data        push side
//   out_valid, out_ready, out_data     pop side, out_data is the registered head
//   count                              RAM + in-flight + buffer occupancy, 0..15
//   ram_wr_en, ram_wr_addr, ram_wr_data  RAM write port
//   ram_rd_en, ram_rd_addr             RAM read request
//   ram_rd_data                        RAM read data, valid RD_LAT cycles after ram_rd_en
module ram12x73_fifo_ctrl
  import ram12x73_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [3:0]        count,
  output logic              ram_wr_en,
  output logic [AW-1:0]     ram_wr_addr,
  output logic [WIDTH-1:0]  ram_wr_data,
  output logic              ram_rd_en,
  output logic [AW-1:0]     ram_rd_addr,
  input  logic [WIDTH-1:0]  ram_rd_data
);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     ram_cnt;
  logic [RD_LAT-1:0] pipe;       // one bit per outstanding read, oldest at the top
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     credit_used;
  logic [OW-1:0]     obuf_cnt;
  logic              push;
  logic              pop;
  logic              issue;
  logic              capture;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pipe[i]);
  end

  // Gated by rst_n so nothing reaches the macro while reset is held.
  assign in_ready = rst_n && (ram_cnt != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // A read may issue only if its word is guaranteed a buffer slot on return.
  // Counting this cycle's pop as credit is what allows back-to-back issue.
  assign credit_used = inflight + CW'(obuf_cnt) - CW'(pop);
  assign issue       = rst_n && (ram_cnt != '0) && (credit_used < CW'(OBUF));
  assign capture     = pipe[RD_LAT-1];

  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = in_data;
  assign ram_rd_en   = issue;
  assign ram_rd_addr = rd_ptr;

  // The macro latches read data at the issue edge, so the slot is free then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      pipe    <= '0;
    end else begin
      if (push)  wr_ptr <= ram_ptr_inc(wr_ptr);
      if (issue) rd_ptr <= ram_ptr_inc(rd_ptr);
      case ({push, issue})
        2'b10:   ram_cnt <= ram_cnt + CW'(1);
        2'b01:   ram_cnt <= ram_cnt - CW'(1);
        default: ram_cnt <= ram_cnt;
      endcase
      pipe <= {pipe[RD_LAT-2:0], issue};
    end
  end

  // ram_rd_data is only looked at when the oldest pipe stage is set.
  ram_rd_obuf u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (ram_rd_data),
    .pop       (pop),
    .head_data (out_data),
    .cnt       (obuf_cnt),
    .valid     (out_valid)
  );

  assign count = ram_cnt + inflight + CW'(obuf_cnt);

endmodule

// File: tb/tb_ram12x73_fifo_ctrl.sv
// tb/tb_ram12x73_fifo_ctrl.sv - scoreboard bench for ram12x73_fifo_ctrl with a 2-cycle RAM model
module tb_ram12x73_fifo_ctrl;
  import ram12x73_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  word_t         in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  word_t         out_data;
  logic [3:0]    count;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  word_t         ram_wr_data;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  word_t         ram_rd_data;

  int total = 0;
  int bad = 0;
  int occ = 0;
  int rd_issues = 0;
  int pops = 0;
  int exp_wr = 0;
  int exp_rd = 0;
  word_t q[$];

  always #5 clk = ~clk;

  ram12x73_fifo_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  // RAM macro model: registered read, data valid two edges after ram_rd_en.
  word_t mem [16];
  word_t s1 = '0;
  word_t s2 = '0;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    s1 <= ram_rd_en ? mem[ram_rd_addr] : word_t'(73'h1_DEAD_BEEF_0BAD_F00D);
    s2 <= s1;
  end
  assign ram_rd_data = s2;

  task automatic chk(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard, occupancy model and RAM address sequence.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      occ = 0;
      exp_wr = 0;
      exp_rd = 0;
    end else begin
      chk("count", word_t'(count), word_t'(occ));
      if (ram_wr_en) begin
        chk("wr_addr", word_t'(ram_wr_addr), word_t'(exp_wr));
        exp_wr = (exp_wr == DEPTH - 1) ? 0 : exp_wr + 1;
      end
      if (ram_rd_en) begin
        chk("rd_addr", word_t'(ram_rd_addr), word_t'(exp_rd));
        exp_rd = (exp_rd == DEPTH - 1) ? 0 : exp_rd + 1;
        rd_issues++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got %0h expected no word at %0t", out_data, $time);
        end else begin
          chk("sb_data", out_data, q.pop_front());
        end
        pops++;
        occ--;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        occ++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (count == 4'd0 && !out_valid) done = 1'b1;
      tick;
    end
    chk(name, word_t'(count), word_t'(0));
  endtask

  task automatic fill15(input int base);
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_data  = word_t'(base + i);
      @(negedge clk);
      chk("fill_in_ready", word_t'(in_ready), word_t'(1));
      tick;
    end
    in_valid = 1'b0;
  endtask

  // Single word: pushed in cycle 0, must be visible in cycle 4.
  task automatic single_word(input word_t d, input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    @(negedge clk);
    chk({tag, "_wr_en"}, word_t'(ram_wr_en), word_t'(1));
    chk({tag, "_wr_addr"}, word_t'(ram_wr_addr), word_t'(0));
    chk({tag, "_wr_data"}, ram_wr_data, d);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_rd_en"}, word_t'(ram_rd_en), word_t'(1));
    chk({tag, "_rd_addr"}, word_t'(ram_rd_addr), word_t'(0));
    for (int c = 2; c < 4; c++) begin
      tick;
      @(negedge clk);
      chk({tag, "_early_valid"}, word_t'(out_valid), word_t'(0));
    end
    tick;
    @(negedge clk);
    chk({tag, "_c4_valid"}, word_t'(out_valid), word_t'(1));
    chk({tag, "_c4_data"}, out_data, d);
    tick;
    @(negedge clk);
    chk({tag, "_after_count"}, word_t'(count), word_t'(0));
    chk({tag, "_after_valid"}, word_t'(out_valid), word_t'(0));
    tick;
  endtask

  initial begin
    int snap;
    int idx;

    // Reset state.
    @(negedge clk);
    chk("rst_in_ready", word_t'(in_ready), word_t'(0));
    chk("rst_rd_en", word_t'(ram_rd_en), word_t'(0));
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", word_t'(out_valid), word_t'(0));
    chk("rst_out_data", out_data, word_t'(0));
    chk("rst_count", word_t'(count), word_t'(0));
    chk("rst_in_ready_hi", word_t'(in_ready), word_t'(1));
    tick;

    single_word(word_t'(73'h1_6789_ABCD_EF01_2345), "single");

    // Fill with out_ready low: 12 in RAM plus 3 in the buffer.
    snap = rd_issues;
    fill15(0);
    @(negedge clk);
    chk("fill_in_ready_low", word_t'(in_ready), word_t'(0));
    chk("fill_count", word_t'(count), word_t'(15));
    tick;
    chk("fill_rd_issues", word_t'(rd_issues - snap), word_t'(3));
    drain("fill_drain");

    // Wrap: 40 back-to-back words, 39 outputs by the end of cycle 42.
    out_ready = 1'b1;
    snap = pops;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = {word_t'(i) << 40} | word_t'(32'hC0DE_0000 + i);
      @(negedge clk);
      chk("wrap_in_ready", word_t'(in_ready), word_t'(1));
      tick;
    end
    in_valid = 1'b0;
    for (int c = 40; c < 43; c++) tick;
    chk("wrap_throughput", word_t'(pops - snap), word_t'(39));
    tick;
    chk("wrap_all_out", word_t'(pops - snap), word_t'(40));
    drain("wrap_drain");

    // Random backpressure over a 100-word stream.
    idx = 0;
    for (int c = 0; c < 2000 && idx < 100; c++) begin
      in_valid  = 1'b1;
      in_data   = word_t'(idx * 32'h0101_0101) ^ (word_t'(idx) << 64);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) idx++;
      tick;
    end
    in_valid = 1'b0;
    chk("bp_pushed", word_t'(idx), word_t'(100));
    drain("bp_drain");

    // Full FIFO: push refused while a pop is accepted, then accepted next cycle.
    fill15(200);
    in_valid  = 1'b1;
    in_data   = word_t'(555);
    out_ready = 1'b1;
    @(negedge clk);
    chk("simul_in_ready", word_t'(in_ready), word_t'(0));
    chk("simul_pop", word_t'(out_valid), word_t'(1));
    tick;
    out_ready = 1'b0;
    @(negedge clk);
    chk("simul_in_ready_next", word_t'(in_ready), word_t'(1));
    tick;
    in_valid = 1'b0;
    drain("simul_drain");

    // Reset with two reads in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = word_t'(32'hBAD0 + i);
      tick;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", word_t'(out_valid), word_t'(0));
    chk("mrst_count", word_t'(count), word_t'(0));
    chk("mrst_rd_en", word_t'(ram_rd_en), word_t'(0));
    chk("mrst_wr_en", word_t'(ram_wr_en), word_t'(0));
    tick;
    tick;
    rst_n = 1'b1;
    single_word(word_t'(73'h0_0F0F_1234_5678_9ABC), "post_rst");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_no_stale", word_t'(out_valid), word_t'(0));
      tick;
    end
    chk("sb_empty_end", word_t'(q.size()), word_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
